// File: rtl/pbkdf2_job_ctrl.sv
// pbkdf2_job_ctrl
// Job initiator for the PBKDF2 core. It accepts one password/salt job,
// pulses the core's reset and then its start, and waits for a fresh rising
// edge on the core's ready. The captured key, or a timeout result, is held
// in a one-entry buffer until the downstream side accepts it.
//
// Optional feature macro: PBKDF2_CHECK_EN
//   Adds i_golden, o_match and o_err_cnt. The golden key is sampled on
//   accept and compared when the key is captured.

module pbkdf2_job_ctrl #(
    parameter int PW_W         = 1088,
    parameter int SALT_W       = 128,
    parameter int KEY_W        = 256,
    parameter int RST_CYCLES   = 1,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 10000,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    // job request side
    input  logic              i_valid,
    output logic              o_in_ready,
    input  logic [PW_W-1:0]   i_pw,
    input  logic [SALT_W-1:0] i_salt,
    // PBKDF2 core side
    output logic              o_core_rst_n,
    output logic              o_core_start,
    output logic [PW_W-1:0]   o_core_pw,
    output logic [SALT_W-1:0] o_core_salt,
    input  logic              i_core_ready,
    input  logic [KEY_W-1:0]  i_core_key,
    // result side
    output logic              o_key_valid,
    input  logic              i_key_ready,
    output logic [KEY_W-1:0]  o_key,
    output logic              o_timeout
`ifdef PBKDF2_CHECK_EN
    ,
    input  logic [KEY_W-1:0]  i_golden,
    output logic              o_match,
    output logic [15:0]       o_err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CRST  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // CRST counts 0..RST_CYCLES-1; START entry reloads the counter with 1,
    // so in START/BUSY it holds the number of cycles spent since START entry.
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ready_q;
    logic               rise;
    logic               tmo_hit;
    logic               accept;
    logic               handshake;

    // Next-state decode; the edge wins over a simultaneous timeout
    always_comb begin
        state_d   = state_q;
        rise      = i_core_ready & ~ready_q;
        tmo_hit   = (cnt_q >= TMO_LIM);
        accept    = (state_q == IDLE) & i_valid;
        handshake = o_key_valid & i_key_ready;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
        case (state_q)
            IDLE:    if (i_valid)            state_d = CRST;
            CRST:    if (cnt_q == RST_LAST)   state_d = START;
            START:   if (cnt_q == START_LAST) state_d = BUSY;
            BUSY:    if (rise || tmo_hit)     state_d = DONE;
            DONE:    if (handshake)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // State register plus the handshake/core-control outputs, all derived
    // from the next state so they are registered yet aligned with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            o_in_ready   <= 1'b1;
            o_core_rst_n <= 1'b0;
            o_core_start <= 1'b0;
            o_key_valid  <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_in_ready   <= (state_d == IDLE);
            o_core_rst_n <= (state_d != CRST);
            o_core_start <= (state_d == START);
            o_key_valid  <= (state_d == DONE);
        end
    end

    // Phase/timeout counter; saturating, never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE:        if (i_valid) cnt_q <= '0;
                CRST:        cnt_q <= (state_d == START) ? CNT_ONE : cnt_inc;
                START, BUSY: cnt_q <= cnt_inc;
                default:     cnt_q <= cnt_q;
            endcase
        end
    end

    // Previous core ready; forced high in CRST so a ready left over from the
    // prior job is never mistaken for a new rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else if (state_q == CRST) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= i_core_ready;
        end
    end

    // Job operand registers, held stable for the core from accept onwards
    always_ff @(posedge clk) begin
        if (rst) begin
            o_core_pw   <= '0;
            o_core_salt <= '0;
        end else if (accept) begin
            o_core_pw   <= i_pw;
            o_core_salt <= i_salt;
        end
    end

    // Result buffer: key on a ready edge, zero key plus timeout flag on abort
    always_ff @(posedge clk) begin
        if (rst) begin
            o_key     <= '0;
            o_timeout <= 1'b0;
        end else if (state_q == BUSY) begin
            if (rise) begin
                o_key     <= i_core_key;
                o_timeout <= 1'b0;
            end else if (tmo_hit) begin
                o_key     <= '0;
                o_timeout <= 1'b1;
            end
        end
    end

`ifdef PBKDF2_CHECK_EN
    logic [KEY_W-1:0] golden_q;

    // Golden reference captured with the job
    always_ff @(posedge clk) begin
        if (rst) begin
            golden_q <= '0;
        end else if (accept) begin
            golden_q <= i_golden;
        end
    end

    // Match flag, resolved together with the result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            o_match <= 1'b0;
        end else if (state_q == BUSY) begin
            if (rise) begin
                o_match <= (i_core_key == golden_q);
            end else if (tmo_hit) begin
                o_match <= 1'b0;
            end
        end
    end

    // Saturating count of delivered results that did not match
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_cnt <= '0;
        end else if (handshake && !o_match && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pbkdf2_job_ctrl.sv
// Testbench for pbkdf2_job_ctrl: directed jobs drive a hand-scripted core
// model; expected results go into a scoreboard queue that a negedge monitor
// compares against every cycle the result buffer is valid.

module tb_pbkdf2_job_ctrl;

    localparam int PW_W   = 1088;
    localparam int SALT_W = 128;
    localparam int KEY_W  = 256;
    localparam int TMO    = 100;

    localparam logic [KEY_W-1:0]  K1 = {8{32'h1111_A001}};
    localparam logic [KEY_W-1:0]  K2 = {8{32'h2222_B002}};
    localparam logic [KEY_W-1:0]  K3 = {8{32'h3333_C003}};
    localparam logic [KEY_W-1:0]  K4 = {8{32'h4444_D004}};
    localparam logic [KEY_W-1:0]  K5 = {8{32'h5555_E005}};
    localparam logic [KEY_W-1:0]  K6 = {8{32'h6666_F006}};
    localparam logic [KEY_W-1:0]  KBAD = {8{32'hDEAD_BEEF}};
    localparam logic [KEY_W-1:0]  KONE = 256'd1;
    localparam logic [PW_W-1:0]   PW1 = {34{32'hA1A1_0001}};
    localparam logic [PW_W-1:0]   PW2 = {34{32'hA2A2_0002}};
    localparam logic [PW_W-1:0]   PW3 = {34{32'hA3A3_0003}};
    localparam logic [SALT_W-1:0] S1  = {4{32'h5A17_0001}};
    localparam logic [SALT_W-1:0] S2  = {4{32'h5A17_0002}};
    localparam logic [SALT_W-1:0] S3  = {4{32'h5A17_0003}};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_in_ready;
    logic [PW_W-1:0]   i_pw = '0;
    logic [SALT_W-1:0] i_salt = '0;
    logic              o_core_rst_n;
    logic              o_core_start;
    logic [PW_W-1:0]   o_core_pw;
    logic [SALT_W-1:0] o_core_salt;
    logic              i_core_ready = 1'b0;
    logic [KEY_W-1:0]  i_core_key = '0;
    logic              o_key_valid;
    logic              i_key_ready = 1'b1;
    logic [KEY_W-1:0]  o_key;
    logic              o_timeout;
`ifdef PBKDF2_CHECK_EN
    logic [KEY_W-1:0]  i_golden = '0;
    logic              o_match;
    logic [15:0]       o_err_cnt;
`endif

    typedef struct {
        logic [KEY_W-1:0] key;
        logic             tmo;
        logic             match;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   n_checks = 0;
    int   n_pass   = 0;

    pbkdf2_job_ctrl #(
        .PW_W(PW_W), .SALT_W(SALT_W), .KEY_W(KEY_W),
        .RST_CYCLES(1), .START_CYCLES(2), .TIMEOUT(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_pw(i_pw), .i_salt(i_salt),
        .o_core_rst_n(o_core_rst_n), .o_core_start(o_core_start),
        .o_core_pw(o_core_pw), .o_core_salt(o_core_salt),
        .i_core_ready(i_core_ready), .i_core_key(i_core_key),
        .o_key_valid(o_key_valid), .i_key_ready(i_key_ready),
        .o_key(o_key), .o_timeout(o_timeout)
`ifdef PBKDF2_CHECK_EN
        , .i_golden(i_golden), .o_match(o_match), .o_err_cnt(o_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [KEY_W-1:0] act,
                         input logic [KEY_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job and return one cycle after the accept edge (cycle 1)
    task automatic submit(input logic [PW_W-1:0] pw, input logic [SALT_W-1:0] salt,
                          input logic [KEY_W-1:0] gold);
        i_pw    = pw;
        i_salt  = salt;
`ifdef PBKDF2_CHECK_EN
        i_golden = gold;
`else
        if (gold == '1) i_pw = pw;
`endif
        i_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_in_ready) begin
                tick();
                i_valid = 1'b0;
                return;
            end
            tick();
        end
        n_checks++;
        $display("FAIL accept_wait: o_in_ready stayed 0, expected 1 within 50 cycles");
        i_valid = 1'b0;
    endtask

    // Scoreboard monitor: every valid cycle must match the head entry
    always @(negedge clk) begin
        if (!rst && o_key_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: o_key_valid=1 with key %h, expected no result", o_key);
            end else begin
                head = sb[0];
                check("result_key", o_key, head.key);
                check1("result_timeout", o_timeout, head.tmo);
`ifdef PBKDF2_CHECK_EN
                check1("result_match", o_match, head.match);
`endif
                if (i_key_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values while rst is high
        tick(); tick();
        check1("rst_in_ready", o_in_ready, 1'b1);
        check1("rst_core_rst_n", o_core_rst_n, 1'b0);
        check1("rst_core_start", o_core_start, 1'b0);
        check1("rst_key_valid", o_key_valid, 1'b0);
        check("rst_key", o_key, '0);
        check1("rst_timeout", o_timeout, 1'b0);
        check1("rst_pw_zero", o_core_pw == '0, 1'b1);
        check1("rst_salt_zero", o_core_salt == '0, 1'b1);
`ifdef PBKDF2_CHECK_EN
        check("rst_err_cnt", 256'(o_err_cnt), '0);
`endif
        rst = 1'b0;
        tick();
        check1("idle_core_rst_n", o_core_rst_n, 1'b1);

        // job 1: nominal timing, ready 40 cycles after start falls
        submit(PW1, S1, K1);
        check1("j1_c1_rst_n", o_core_rst_n, 1'b0);
        check1("j1_c1_in_ready", o_in_ready, 1'b0);
        check1("j1_c1_start", o_core_start, 1'b0);
        check1("j1_pw", o_core_pw == PW1, 1'b1);
        check1("j1_salt", o_core_salt == S1, 1'b1);
        tick();
        check1("j1_c2_start", o_core_start, 1'b1);
        check1("j1_c2_rst_n", o_core_rst_n, 1'b1);
        tick();
        check1("j1_c3_start", o_core_start, 1'b1);
        tick();
        check1("j1_c4_start", o_core_start, 1'b0);
        repeat (40) tick();
        check1("j1_c44_valid", o_key_valid, 1'b0);
        i_core_ready = 1'b1;
        i_core_key   = K1;
        sb.push_back('{key: K1, tmo: 1'b0, match: 1'b1});
        tick();
        check1("j1_c45_valid", o_key_valid, 1'b1);
        tick();
        check1("j1_after_valid", o_key_valid, 1'b0);
        check1("j1_after_in_ready", o_in_ready, 1'b1);

        // job 2: backpressure in DONE, golden wrong in bit 0
        i_core_ready = 1'b0;
        submit(PW2, S2, K2 ^ KONE);
        repeat (13) tick();
        i_key_ready  = 1'b0;
        i_core_ready = 1'b1;
        i_core_key   = K2;
        sb.push_back('{key: K2, tmo: 1'b0, match: 1'b0});
        tick();
        i_core_key = KBAD;
        i_pw       = PW3;
        i_salt     = S3;
`ifdef PBKDF2_CHECK_EN
        i_golden   = K3;
`endif
        i_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check1("j2_bp_valid", o_key_valid, 1'b1);
            check1("j2_bp_in_ready", o_in_ready, 1'b0);
            check("j2_bp_key", o_key, K2);
            tick();
        end
        i_key_ready = 1'b1;
        tick();
        check1("j2_hs_valid", o_key_valid, 1'b0);
        check1("j2_hs_in_ready", o_in_ready, 1'b1);
`ifdef PBKDF2_CHECK_EN
        check("j2_err_cnt", 256'(o_err_cnt), 256'd1);
`endif

        // job 3: accepted from the held i_valid; core ready is stale-high
        tick();
        i_valid = 1'b0;
        check1("j3_c1_rst_n", o_core_rst_n, 1'b0);
        check1("j3_pw", o_core_pw == PW3, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check1("j3_stale_valid", o_key_valid, 1'b0);
            tick();
        end
        i_core_ready = 1'b0;
        repeat (3) tick();
        i_core_ready = 1'b1;
        i_core_key   = K3;
        sb.push_back('{key: K3, tmo: 1'b0, match: 1'b1});
        tick();
        check1("j3_fresh_valid", o_key_valid, 1'b1);
        tick();

        // job 4: core never raises ready -> timeout 100 cycles after START entry
        i_core_ready = 1'b0;
        i_core_key   = K4;
        submit(PW1, S1, '0);
        sb.push_back('{key: '0, tmo: 1'b1, match: 1'b0});
        repeat (100) tick();
        check1("j4_c101_valid", o_key_valid, 1'b0);
        tick();
        check1("j4_c102_valid", o_key_valid, 1'b1);
        check1("j4_c102_timeout", o_timeout, 1'b1);
        tick();
`ifdef PBKDF2_CHECK_EN
        check("j4_err_cnt", 256'(o_err_cnt), 256'd2);
`endif

        // job 5: reset asserted in BUSY at cycle 30, no result ever emitted
        submit(PW2, S2, K5);
        repeat (29) tick();
        check1("j5_c30_in_ready", o_in_ready, 1'b0);
        rst = 1'b1;
        tick();
        check1("j5_rst_in_ready", o_in_ready, 1'b1);
        check1("j5_rst_valid", o_key_valid, 1'b0);
        check1("j5_rst_start", o_core_start, 1'b0);
        check1("j5_rst_core_rst_n", o_core_rst_n, 1'b0);
        check1("j5_rst_pw_zero", o_core_pw == '0, 1'b1);
`ifdef PBKDF2_CHECK_EN
        check("j5_rst_err_cnt", 256'(o_err_cnt), '0);
`endif
        rst = 1'b0;
        i_core_ready = 1'b1;
        i_core_key   = K5;
        repeat (20) tick();
        check1("j5_no_result", o_key_valid, 1'b0);

        // job 6: recovery, ready rises on the first BUSY cycle
        i_core_ready = 1'b0;
        submit(PW3, S3, K6);
        repeat (3) tick();
        i_core_ready = 1'b1;
        i_core_key   = K6;
        sb.push_back('{key: K6, tmo: 1'b0, match: 1'b1});
        tick();
        check1("j6_valid", o_key_valid, 1'b1);
        repeat (5) tick();
        check1("sb_drained", sb.size() == 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
